nav_arb: RTL and testbench

NAV_ARB -- requirements
Module: nav_arb

---
 rtl/nav_arb.sv | 162 ++++++++++++++++
 tb/tb_nav_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nav_arb.sv
// rtl/nav_arb.sv - two-requester navigation arbiter with battery gating and move timeout
module nav_arb #(
    parameter int unsigned TMO_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_md,
    input  logic               strt_hdng_cmd,
    input  logic               strt_mv_cmd,
    input  logic               stp_lft_cmd,
    input  logic               stp_rght_cmd,
    input  logic signed [11:0] dsrd_hdng_cmd,
    input  logic               strt_hdng_slv,
    input  logic               strt_mv_slv,
    input  logic               stp_lft_slv,
    input  logic               stp_rght_slv,
    input  logic signed [11:0] dsrd_hdng_slv,
    input  logic               mv_cmplt,
    input  logic               batt_low,
    output logic               strt_hdng,
    output logic               strt_mv,
    output logic               stp_lft,
    output logic               stp_rght,
    output logic        [11:0] dsrd_hdng,
    output logic               mv_cmplt_cmd,
    output logic               mv_cmplt_slv,
    output logic               busy,
    output logic               mv_tmo,
    output logic               rej
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD_BSY = 2'd1,
        SLV_BSY = 2'd2
    } state_t;

    // Last counter value of a move; reaching it without completion ends the move.
    localparam logic [23:0] TMO_LAST = 24'(TMO_CYC - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        strt_hdng_q, strt_hdng_d;
    logic        strt_mv_q, strt_mv_d;
    logic        stp_lft_q, stp_lft_d;
    logic        stp_rght_q, stp_rght_d;
    logic [11:0] dsrd_hdng_q, dsrd_hdng_d;
    logic        cmplt_cmd_q, cmplt_cmd_d;
    logic        cmplt_slv_q, cmplt_slv_d;
    logic        mv_tmo_q, mv_tmo_d;
    logic        rej_q, rej_d;

    // Request fields of whichever requester cmd_md currently selects.
    logic        sel_hdng;
    logic        sel_mv;
    logic        sel_lft;
    logic        sel_rght;
    logic [11:0] sel_dsrd;
    logic        move_done;

    // Select the eligible requester's start pulses and move arguments.
    always_comb begin
        sel_hdng = cmd_md ? strt_hdng_cmd : strt_hdng_slv;
        sel_mv   = cmd_md ? strt_mv_cmd   : strt_mv_slv;
        sel_lft  = cmd_md ? stp_lft_cmd   : stp_lft_slv;
        sel_rght = cmd_md ? stp_rght_cmd  : stp_rght_slv;
        sel_dsrd = cmd_md ? dsrd_hdng_cmd : dsrd_hdng_slv;
    end

    // Next-state and registered-output logic; pulses default low, arguments hold.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        strt_hdng_d = 1'b0;
        strt_mv_d   = 1'b0;
        stp_lft_d   = stp_lft_q;
        stp_rght_d  = stp_rght_q;
        dsrd_hdng_d = dsrd_hdng_q;
        cmplt_cmd_d = 1'b0;
        cmplt_slv_d = 1'b0;
        mv_tmo_d    = 1'b0;
        rej_d       = 1'b0;
        move_done   = 1'b0;

        case (state_q)
            IDLE: begin
                // A heading request outranks a move; a move is refused on low battery.
                if (sel_hdng || (sel_mv && !batt_low)) begin
                    strt_hdng_d = sel_hdng;
                    strt_mv_d   = !sel_hdng;
                    stp_lft_d   = sel_lft;
                    stp_rght_d  = sel_rght;
                    dsrd_hdng_d = sel_dsrd;
                    cnt_d       = 24'd0;
                    state_d     = cmd_md ? CMD_BSY : SLV_BSY;
                end else if (sel_mv) begin
                    rej_d = 1'b1;
                end
            end
            CMD_BSY, SLV_BSY: begin
                // Completion and timeout end the move the same way; completion wins a tie.
                move_done = mv_cmplt || (cnt_q == TMO_LAST);
                if (move_done) begin
                    cmplt_cmd_d = (state_q == CMD_BSY);
                    cmplt_slv_d = (state_q == SLV_BSY);
                    mv_tmo_d    = !mv_cmplt;
                    stp_lft_d   = 1'b0;
                    stp_rght_d  = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q != 24'hFF_FFFF) begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                stp_lft_d  = 1'b0;
                stp_rght_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 24'd0;
            strt_hdng_q <= 1'b0;
            strt_mv_q   <= 1'b0;
            stp_lft_q   <= 1'b0;
            stp_rght_q  <= 1'b0;
            dsrd_hdng_q <= 12'h000;
            cmplt_cmd_q <= 1'b0;
            cmplt_slv_q <= 1'b0;
            mv_tmo_q    <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            strt_hdng_q <= strt_hdng_d;
            strt_mv_q   <= strt_mv_d;
            stp_lft_q   <= stp_lft_d;
            stp_rght_q  <= stp_rght_d;
            dsrd_hdng_q <= dsrd_hdng_d;
            cmplt_cmd_q <= cmplt_cmd_d;
            cmplt_slv_q <= cmplt_slv_d;
            mv_tmo_q    <= mv_tmo_d;
            rej_q       <= rej_d;
        end
    end

    assign strt_hdng    = strt_hdng_q;
    assign strt_mv      = strt_mv_q;
    assign stp_lft      = stp_lft_q;
    assign stp_rght     = stp_rght_q;
    assign dsrd_hdng    = dsrd_hdng_q;
    assign mv_cmplt_cmd = cmplt_cmd_q;
    assign mv_cmplt_slv = cmplt_slv_q;
    assign mv_tmo       = mv_tmo_q;
    assign rej          = rej_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_nav_arb.sv
// tb/tb_nav_arb.sv - scoreboard bench for nav_arb against a behavioural move-ownership model
module tb_nav_arb;

    localparam int TMO = 16;

    typedef logic [20:0] ovec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_md;
    logic        strt_hdng_cmd, strt_mv_cmd, stp_lft_cmd, stp_rght_cmd;
    logic [11:0] dsrd_hdng_cmd;
    logic        strt_hdng_slv, strt_mv_slv, stp_lft_slv, stp_rght_slv;
    logic [11:0] dsrd_hdng_slv;
    logic        mv_cmplt;
    logic        batt_low;
    logic        strt_hdng, strt_mv, stp_lft, stp_rght;
    logic [11:0] dsrd_hdng;
    logic        mv_cmplt_cmd, mv_cmplt_slv, busy, mv_tmo, rej;

    always #5 clk = ~clk;

    nav_arb #(.TMO_CYC(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_md        (cmd_md),
        .strt_hdng_cmd (strt_hdng_cmd),
        .strt_mv_cmd   (strt_mv_cmd),
        .stp_lft_cmd   (stp_lft_cmd),
        .stp_rght_cmd  (stp_rght_cmd),
        .dsrd_hdng_cmd (dsrd_hdng_cmd),
        .strt_hdng_slv (strt_hdng_slv),
        .strt_mv_slv   (strt_mv_slv),
        .stp_lft_slv   (stp_lft_slv),
        .stp_rght_slv  (stp_rght_slv),
        .dsrd_hdng_slv (dsrd_hdng_slv),
        .mv_cmplt      (mv_cmplt),
        .batt_low      (batt_low),
        .strt_hdng     (strt_hdng),
        .strt_mv       (strt_mv),
        .stp_lft       (stp_lft),
        .stp_rght      (stp_rght),
        .dsrd_hdng     (dsrd_hdng),
        .mv_cmplt_cmd  (mv_cmplt_cmd),
        .mv_cmplt_slv  (mv_cmplt_slv),
        .busy          (busy),
        .mv_tmo        (mv_tmo),
        .rej           (rej)
    );

    ovec_t act;
    assign act = {strt_hdng, strt_mv, stp_lft, stp_rght, dsrd_hdng,
                  mv_cmplt_cmd, mv_cmplt_slv, busy, mv_tmo, rej};

    ovec_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // Model state: who owns the navigator (0 none, 1 command, 2 solver),
    // how many busy cycles have elapsed, and the argument values last handed over.
    int          own = 0;
    int          elapsed = 0;
    logic        m_lft = 1'b0;
    logic        m_rght = 1'b0;
    logic [11:0] m_hdng = 12'h000;

    // Predict what the outputs show after the coming edge, given the inputs now applied.
    task automatic model_step();
        logic r_h, r_m;
        logic e_sh, e_sm, e_cc, e_cs, e_to, e_rej;
        e_sh = 1'b0; e_sm = 1'b0; e_cc = 1'b0; e_cs = 1'b0; e_to = 1'b0; e_rej = 1'b0;
        if (!rst_n) begin
            own = 0; elapsed = 0; m_lft = 1'b0; m_rght = 1'b0; m_hdng = 12'h000;
        end else if (own == 0) begin
            r_h = cmd_md ? strt_hdng_cmd : strt_hdng_slv;
            r_m = cmd_md ? strt_mv_cmd : strt_mv_slv;
            if (r_h || (r_m && !batt_low)) begin
                e_sh    = r_h;
                e_sm    = !r_h;
                own     = cmd_md ? 1 : 2;
                elapsed = 0;
                m_lft   = cmd_md ? stp_lft_cmd : stp_lft_slv;
                m_rght  = cmd_md ? stp_rght_cmd : stp_rght_slv;
                m_hdng  = cmd_md ? dsrd_hdng_cmd : dsrd_hdng_slv;
            end else if (r_m) begin
                e_rej = 1'b1;
            end
        end else begin
            if (mv_cmplt || elapsed >= TMO - 1) begin
                e_to   = !mv_cmplt;
                e_cc   = (own == 1);
                e_cs   = (own == 2);
                own    = 0;
                m_lft  = 1'b0;
                m_rght = 1'b0;
            end else begin
                elapsed = elapsed + 1;
            end
        end
        exp_q.push_back({e_sh, e_sm, m_lft, m_rght, m_hdng, e_cc, e_cs, (own != 0), e_to, e_rej});
    endtask

    // Record the expectation, let one edge happen, then return just after it to drive again.
    task automatic step();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        strt_hdng_cmd = 1'b0; strt_mv_cmd = 1'b0;
        strt_hdng_slv = 1'b0; strt_mv_slv = 1'b0;
        mv_cmplt = 1'b0;
    endtask

    task automatic check_now(input string name, input logic ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s t=%0t outputs=%h", name, $time, act);
        end
    endtask

    // Monitor: compare each post-edge output snapshot with the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ovec_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t got=%h exp=%h (hdng,mv,lft,rght,dsrd[12],cc,cs,busy,tmo,rej)",
                         $time, act, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; cmd_md = 1'b0; batt_low = 1'b0;
        stp_lft_cmd = 1'b0; stp_rght_cmd = 1'b0; dsrd_hdng_cmd = 12'h000;
        stp_lft_slv = 1'b0; stp_rght_slv = 1'b0; dsrd_hdng_slv = 12'h000;
        quiet();
        repeat (3) step();
        check_now("reset state", act === 21'd0);
        rst_n = 1'b1;

        // Command grant and completion.
        cmd_md = 1'b1; strt_mv_cmd = 1'b1; dsrd_hdng_cmd = 12'h3FF; stp_lft_cmd = 1'b1;
        step(); quiet(); stp_lft_cmd = 1'b0;
        repeat (3) step();
        mv_cmplt = 1'b1; step(); quiet();
        repeat (2) step();

        // Request from the unselected requester.
        cmd_md = 1'b0; strt_mv_cmd = 1'b1;
        step(); quiet(); repeat (2) step();

        // Battery low: move refused, heading granted.
        batt_low = 1'b1; strt_mv_slv = 1'b1;
        step(); quiet(); step();
        strt_hdng_slv = 1'b1; dsrd_hdng_slv = 12'hC00;
        step(); quiet(); repeat (2) step();
        mv_cmplt = 1'b1; step(); quiet();
        batt_low = 1'b0; step();

        // Ownership retained when cmd_md flips mid-move.
        strt_mv_slv = 1'b1; stp_rght_slv = 1'b1; dsrd_hdng_slv = 12'h123;
        step(); quiet(); stp_rght_slv = 1'b0;
        cmd_md = 1'b1; strt_mv_cmd = 1'b1; step(); quiet();
        step(); mv_cmplt = 1'b1; step(); quiet(); step();

        // Timeout with no completion, then completion on the last allowed cycle.
        strt_mv_cmd = 1'b1; stp_lft_cmd = 1'b1; step(); quiet();
        repeat (TMO) step();
        check_now("expired wait", (mv_tmo === 1'b1) && (mv_cmplt_cmd === 1'b1) && (busy === 1'b0));
        repeat (3) step();
        strt_mv_cmd = 1'b1; step(); quiet();
        repeat (TMO - 1) step();
        mv_cmplt = 1'b1; step(); quiet();
        check_now("completion at limit", (mv_tmo === 1'b0) && (mv_cmplt_cmd === 1'b1) && (busy === 1'b0));
        repeat (2) step();

        // Both starts at once: heading wins.
        strt_hdng_cmd = 1'b1; strt_mv_cmd = 1'b1; dsrd_hdng_cmd = 12'h7A5;
        step(); quiet(); mv_cmplt = 1'b1; step(); quiet(); step();

        // Reset mid solver move, then a request in the first cycle after reset.
        cmd_md = 1'b0; strt_mv_slv = 1'b1; dsrd_hdng_slv = 12'h456; stp_lft_slv = 1'b1;
        step(); quiet(); repeat (3) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check_now("reset mid-move", (busy === 1'b0) && (dsrd_hdng === 12'h000));
        strt_hdng_slv = 1'b1; dsrd_hdng_slv = 12'h0F0;
        step(); quiet(); repeat (3) step();
        mv_cmplt = 1'b1; step(); quiet(); step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0) cmd_md = ~cmd_md;
            batt_low      = ($urandom_range(0, 3) == 0);
            strt_hdng_cmd = ($urandom_range(0, 9) == 0);
            strt_mv_cmd   = ($urandom_range(0, 6) == 0);
            strt_hdng_slv = ($urandom_range(0, 9) == 0);
            strt_mv_slv   = ($urandom_range(0, 6) == 0);
            stp_lft_cmd   = 1'($urandom);
            stp_rght_cmd  = 1'($urandom);
            stp_lft_slv   = 1'($urandom);
            stp_rght_slv  = 1'($urandom);
            dsrd_hdng_cmd = 12'($urandom);
            dsrd_hdng_slv = 12'($urandom);
            mv_cmplt      = ($urandom_range(0, 19) == 0);
            step();
        end
        rst_n = 1'b1; quiet(); step();

        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
